uart_tx_arbiter: RTL and testbench

Shares the single uart_tx serializer (CLKS_PER_BIT = 48000000/115200) between up to four byte-stream requesters, e.g. the status-screen dumper and USB debug taps.
- Grants whole messages, framed by a last flag, in round-robin order.
- Drives the serializer's DV/byte inputs and sequences on its active/done outputs.
- Releases a stalled requester via a watchdog.
- Sits between the requesters and uart_tx inside usb_top.

---
 rtl/uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx serializer between up to four byte-stream
// requesters. Whole messages (terminated by req_last) are granted round-robin;
// a watchdog revokes a grant whose owner stalls mid-message.
// Build option: define UART_ARB_PREFIX_EN to precede every message with the
// ASCII channel tag "0"+g sent as its own serializer frame.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 4800,
    parameter int unsigned TW      = 13
) (
    input  logic              clk48,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    input  logic              tx_busy,
    input  logic              tx_done,
    output logic              arb_busy,
    output logic              timeout_err
);

`ifdef UART_ARB_PREFIX_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFIX,
        S_PWAIT,
        S_SEND,
        S_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;
`endif

    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [1:0]      r_gidx;
    logic [1:0]      r_last_grant;
    logic            r_last_q;
    logic            r_tx_dv;
    logic [7:0]      r_tx_byte;
    logic            r_arb_busy;
    logic            r_timeout_err;
    logic [TW-1:0]   r_to_cnt;

    logic [3:0]      w_valid4;
    logic [3:0]      w_last4;
    logic [31:0]     w_data4;
    logic [2:0]      w_cand;
    logic            w_pick_found;
    logic [1:0]      w_pick_idx;
    logic [3:0]      w_pick_oh;
    logic            w_gvalid;
    logic            w_glast;
    logic [7:0]      w_gdata;
    logic            w_hs;
    logic [3:0]      w_ready4;

    // Widen the request bundle to four channels so selection logic is fixed-width.
    always_comb begin
        w_valid4 = '0;
        w_last4  = '0;
        w_data4  = '0;
        w_valid4[NREQ-1:0]   = req_valid;
        w_last4[NREQ-1:0]    = req_last;
        w_data4[8*NREQ-1:0]  = req_data;
    end

    // Round-robin pick: first valid channel searching upward from last_grant+1.
    always_comb begin
        w_cand       = '0;
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_last_grant} + 3'(k);
            if (w_cand >= 3'(NREQ)) begin
                w_cand = w_cand - 3'(NREQ);
            end
            if (!w_pick_found && w_valid4[w_cand[1:0]]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = w_cand[1:0];
            end
        end
        w_pick_oh = 4'b0001 << w_pick_idx;
    end

    // Granted channel's byte, last flag, valid and the handshake / ready vector.
    always_comb begin
        w_gdata = '0;
        case (r_gidx)
            2'd0:    w_gdata = w_data4[7:0];
            2'd1:    w_gdata = w_data4[15:8];
            2'd2:    w_gdata = w_data4[23:16];
            default: w_gdata = w_data4[31:24];
        endcase
        w_gvalid = w_valid4[r_gidx];
        w_glast  = w_last4[r_gidx];
        w_hs     = (r_state == S_SEND) && w_gvalid && !tx_busy && !r_tx_dv;
        w_ready4 = '0;
        if (w_hs) begin
            w_ready4[r_gidx] = 1'b1;
        end
    end

    // Arbitration FSM with registered grant, strobe, byte, busy and watchdog.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_gidx        <= '0;
            r_last_grant  <= 2'(NREQ - 1);
            r_last_q      <= 1'b0;
            r_tx_dv       <= 1'b0;
            r_tx_byte     <= '0;
            r_arb_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_to_cnt      <= '0;
        end else begin
            r_tx_dv       <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_found) begin
                        r_gidx     <= w_pick_idx;
                        r_grant    <= w_pick_oh[NREQ-1:0];
                        r_to_cnt   <= '0;
                        r_arb_busy <= 1'b1;
`ifdef UART_ARB_PREFIX_EN
                        r_state    <= S_PREFIX;
`else
                        r_state    <= S_SEND;
`endif
                    end
                end
`ifdef UART_ARB_PREFIX_EN
                S_PREFIX: begin
                    if (!tx_busy && !r_tx_dv) begin
                        r_tx_byte <= 8'h30 + {6'd0, r_gidx};
                        r_tx_dv   <= 1'b1;
                        r_state   <= S_PWAIT;
                    end
                end
                S_PWAIT: begin
                    if (tx_done) begin
                        r_to_cnt <= '0;
                        r_state  <= S_SEND;
                    end
                end
`endif
                S_SEND: begin
                    if (w_hs) begin
                        r_tx_byte <= w_gdata;
                        r_last_q  <= w_glast;
                        r_tx_dv   <= 1'b1;
                        r_to_cnt  <= '0;
                        r_state   <= S_WAIT;
                    end else if (!w_gvalid) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_grant       <= '0;
                            r_last_grant  <= r_gidx;
                            r_arb_busy    <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (r_last_q) begin
                            r_grant      <= '0;
                            r_last_grant <= r_gidx;
                            r_arb_busy   <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_to_cnt <= '0;
                            r_state  <= S_SEND;
                        end
                    end
                end
                default: begin
                    r_grant    <= '0;
                    r_arb_busy <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = w_ready4[NREQ-1:0];
    assign grant       = r_grant;
    assign tx_dv       = r_tx_dv;
    assign tx_byte     = r_tx_byte;
    assign arb_busy    = r_arb_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized requesters and a behavioural uart_tx model drive
// the arbiter; expected line bytes come from a message-level round-robin model.
// Honours UART_ARB_PREFIX_EN the same way as the design.
module tb_uart_tx_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 4800;
    localparam int unsigned TW      = 13;
`ifdef UART_ARB_PREFIX_EN
    localparam int unsigned PFX = 1;
`else
    localparam int unsigned PFX = 0;
`endif

    logic              clk48;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              tx_busy;
    logic              tx_done;
    logic              arb_busy;
    logic              timeout_err;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [8:0]  ch_q  [NREQ][$];
    logic [8:0]  stage [NREQ][$];
    logic [9:0]  exp_q [$];
    int unsigned m_last;
    int          gap [NREQ];
    bit          gap_en;
    bit          drv_flush;
    bit          inj_done;
    int          ser_len;
    bit          spacing_chk;
    bit          msg_started;
    int          last_done_cyc;
    bit          sim_done;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .clk48       (clk48),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .tx_dv       (tx_dv),
        .tx_byte     (tx_byte),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Clock and cycle counter.
    initial begin
        clk48 = 1'b0;
        cyc   = 0;
        forever begin
            #10 clk48 = ~clk48;
            if (clk48) cyc++;
        end
    end

    // Requester drivers: each channel presents the head of its byte queue.
    initial begin : drivers
        logic [NREQ-1:0] acc;
        bit was_last;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk48);
            acc = req_ready & req_valid;
            @(posedge clk48);
            #1;
            for (int c = 0; c < NREQ; c++) begin
                if (drv_flush) begin
                    ch_q[c].delete();
                    gap[c] = 0;
                end else if (acc[c] && ch_q[c].size() != 0) begin
                    was_last = ch_q[c][0][8];
                    void'(ch_q[c].pop_front());
                    gap[c] = (gap_en && !was_last) ? int'($urandom_range(0, 12)) : 0;
                end else if (gap[c] != 0) begin
                    gap[c]--;
                end
                if (ch_q[c].size() != 0 && gap[c] == 0) begin
                    req_valid[c]       = 1'b1;
                    req_data[8*c +: 8] = ch_q[c][0][7:0];
                    req_last[c]        = ch_q[c][0][8];
                end else begin
                    req_valid[c]       = 1'b0;
                    req_data[8*c +: 8] = 8'h00;
                    req_last[c]        = 1'b0;
                end
            end
        end
    end

    // Serializer model: busy for a frame after each strobe, then a done pulse.
    initial begin : serializer
        bit dv_seen;
        int scnt;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        scnt    = 0;
        forever begin
            @(negedge clk48);
            dv_seen = tx_dv;
            @(posedge clk48);
            #1;
            tx_done = 1'b0;
            if (inj_done) begin
                tx_done  = 1'b1;
                inj_done = 1'b0;
            end
            if (dv_seen && !tx_busy) begin
                tx_busy = 1'b1;
                scnt    = (ser_len != 0) ? ser_len : int'($urandom_range(2, 8));
            end else if (tx_busy) begin
                if (scnt <= 1) begin
                    tx_busy = 1'b0;
                    tx_done = 1'b1;
                end else begin
                    scnt--;
                end
            end
        end
    end

    // Line monitor: every strobe must match the next expected (channel, byte).
    initial begin : monitor
        logic [9:0] e;
        logic [3:0] oh;
        forever begin
            @(negedge clk48);
            if (req_ready != '0) chk("ready_owner", 32'(req_ready & ~grant), 0);
            if (tx_dv) begin
                chk("dv_ser_idle", 32'(tx_busy), 0);
                if (spacing_chk && msg_started) chk("byte_spacing", cyc - last_done_cyc, 2);
                msg_started = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("dv_unexpected", exp_q.size(), 1);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e[9:8];
                    chk("tx_byte", 32'(tx_byte), 32'(e[7:0]));
                    chk("grant", 32'(grant), 32'(oh));
                end
            end
            if (tx_done) last_done_cyc = cyc;
            if (!arb_busy) msg_started = 1'b0;
        end
    end

    task automatic stage_byte(input int c, input logic [7:0] d, input bit last);
        stage[c].push_back({last, d});
    endtask

    // Message-level reference: release staged messages and predict line order.
    task automatic commit();
        int unsigned remain;
        int unsigned c;
        bit          found;
        logic [8:0]  b;
        remain = 0;
        c      = 0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < stage[i].size(); j++) begin
                ch_q[i].push_back(stage[i][j]);
                if (stage[i][j][8]) remain++;
            end
        end
        while (remain > 0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ && !found; k++) begin
                c = (m_last + k) % NREQ;
                if (stage[c].size() != 0) found = 1'b1;
            end
            if (PFX != 0) exp_q.push_back({2'(c), 8'(8'h30 + c)});
            do begin
                b = stage[c].pop_front();
                exp_q.push_back({2'(c), b[7:0]});
            end while (!b[8]);
            m_last = c;
            remain--;
        end
    endtask

    function automatic bit q_empty();
        for (int i = 0; i < NREQ; i++) if (ch_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk48);
            if (exp_q.size() == 0 && !arb_busy && !tx_busy && q_empty()) ok = 1'b1;
        end
        chk("drain_left", exp_q.size(), 0);
        chk("drain_idle", 32'(ok), 1);
    endtask

    task automatic do_reset();
        @(negedge clk48);
        rst_n     = 1'b0;
        drv_flush = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) stage[i].delete();
        m_last      = NREQ - 1;
        msg_started = 1'b0;
        repeat (2) @(negedge clk48);
        drv_flush = 1'b0;
        rst_n     = 1'b1;
    endtask

    // Global time limit.
    initial begin
        #4000000;
        if (!sim_done) begin
            $display("FAIL global_timeout: simulation did not complete");
            $fatal(1);
        end
    end

    // Directed and randomized sequences.
    initial begin : main
        int          n;
        bit          got;
        bit          busy_seen;
        bit          busy_dropped;
        int          d;
        int          t;
        int unsigned nm;
        int unsigned ln;
        n_checks = 0;
        n_errors = 0;
        sim_done = 1'b0;
        gap_en   = 1'b0;
        inj_done = 1'b0;
        ser_len  = 0;
        spacing_chk   = 1'b0;
        msg_started   = 1'b0;
        last_done_cyc = 0;
        m_last    = NREQ - 1;
        rst_n     = 1'b0;
        drv_flush = 1'b1;

        repeat (3) @(negedge clk48);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_tx_dv", 32'(tx_dv), 0);
        chk("rst_tx_byte", 32'(tx_byte), 0);
        chk("rst_arb_busy", 32'(arb_busy), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        drv_flush = 1'b0;
        rst_n     = 1'b1;

        // ch0 three-byte message, busy drop one cycle after the final done.
        spacing_chk = 1'b1;
        stage_byte(0, 8'h41, 1'b0);
        stage_byte(0, 8'h42, 1'b0);
        stage_byte(0, 8'h43, 1'b1);
        commit();
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk48);
            if (tx_done) n++;
            if (n == int'(3 + PFX)) got = 1'b1;
        end
        chk("t1_dones", n, 3 + PFX);
        chk("t1_busy_at_done", 32'(arb_busy), 1);
        @(negedge clk48);
        chk("t1_busy_after", 32'(arb_busy), 0);
        chk("t1_grant_after", 32'(grant), 0);
        wait_drain(50);

        // ch1 and ch2 simultaneously after reset.
        do_reset();
        stage_byte(1, 8'hA1, 1'b0);
        stage_byte(1, 8'hA2, 1'b1);
        stage_byte(2, 8'hB1, 1'b0);
        stage_byte(2, 8'hB2, 1'b1);
        commit();
        wait_drain(400);

        // All channels with back-to-back single-byte messages.
        do_reset();
        for (int c = 0; c < NREQ; c++) begin
            stage_byte(c, 8'(8'h50 + c), 1'b1);
            stage_byte(c, 8'(8'h60 + c), 1'b1);
        end
        commit();
        wait_drain(800);

        // Single ch2 message (prefix build adds the tag byte).
        stage_byte(2, 8'h55, 1'b1);
        commit();
        wait_drain(200);
        spacing_chk = 1'b0;

        // Stray done while idle is ignored.
        inj_done = 1'b1;
        repeat (3) begin
            @(negedge clk48);
            chk("stray_busy", 32'(arb_busy), 0);
            chk("stray_dv", 32'(tx_dv), 0);
        end

        // Randomized rounds with mid-message valid gaps.
        gap_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < NREQ; c++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < int'(nm); m++) begin
                    ln = $urandom_range(1, 4);
                    for (int j = 0; j < int'(ln); j++) begin
                        stage_byte(c, 8'($urandom), j == int'(ln) - 1);
                    end
                end
            end
            commit();
            wait_drain(3000);
        end
        gap_en = 1'b0;

        // Watchdog: ch0 stalls after a non-last byte, ch3 waits behind it.
        ch_q[0].push_back({1'b0, 8'h10});
        if (PFX != 0) exp_q.push_back({2'd0, 8'h30});
        exp_q.push_back({2'd0, 8'h10});
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk48);
            if (tx_dv && tx_byte == 8'h10) got = 1'b1;
        end
        chk("to_byte_sent", 32'(got), 1);
        ch_q[3].push_back({1'b1, 8'h33});
        d   = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk48);
            if (tx_done) begin
                got = 1'b1;
                d   = cyc;
            end
        end
        t   = 0;
        got = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 50 && !got; i++) begin
            @(negedge clk48);
            if (timeout_err) begin
                got = 1'b1;
                t   = cyc;
            end
        end
        chk("to_latency", t - d, TIMEOUT + 1);
        chk("to_grant_clr", 32'(grant), 0);
        m_last = 0;
        if (PFX != 0) exp_q.push_back({2'd3, 8'h33});
        exp_q.push_back({2'd3, 8'h33});
        @(negedge clk48);
        chk("to_pulse_len", 32'(timeout_err), 0);
        chk("to_next_grant", 32'(grant), 32'h8);
        wait_drain(300);

        // Reset while the serializer is mid-frame; no strobe until it finishes.
        ser_len = 40;
        stage_byte(1, 8'h99, 1'b1);
        commit();
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk48);
            if (exp_q.size() == 0 && tx_busy) got = 1'b1;
        end
        chk("rst_mid_started", 32'(got), 1);
        do_reset();
        busy_seen = tx_busy;
        chk("rst_ser_still_busy", 32'(busy_seen), 1);
        ser_len = 0;
        stage_byte(2, 8'h77, 1'b1);
        commit();
        busy_dropped = 1'b0;
        got          = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk48);
            if (tx_dv) got = 1'b1;
            else if (!tx_busy) busy_dropped = 1'b1;
        end
        chk("rst_dv_seen", 32'(got), 1);
        chk("rst_no_early_dv", 32'(busy_dropped), 1);
        wait_drain(300);

        sim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
